// File: rtl/demux64_pkg.sv
// Shared sizing defaults, FSM encoding and lane-slice helper for the 1-to-64 distributor.
package demux64_pkg;

   localparam int N_OUT_DEFAULT  = 64;
   localparam int SEL_W_DEFAULT  = 6;
   localparam int DATA_W_DEFAULT = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   // Lowest bit of lane k inside the flattened lane_data bus.
   function automatic int lane_lsb(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/demux_lane.sv
// One-entry holding register for a single output lane; a write wins over a same-cycle ack.
module demux_lane #(
   parameter int DATA_W = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              ack,
   output logic [DATA_W-1:0] data,
   output logic              valid
);

   logic [DATA_W-1:0] data_reg;
   logic [DATA_W-1:0] data_next;
   logic              valid_reg;
   logic              valid_next;

   always_comb begin
      data_next  = data_reg;
      valid_next = valid_reg;
      if (wr) begin
         data_next  = wdata;
         valid_next = 1'b1;
      end else if (ack) begin
         valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_reg  <= '0;
         valid_reg <= 1'b0;
      end else begin
         data_reg  <= data_next;
         valid_reg <= valid_next;
      end
   end

   assign data  = data_reg;
   assign valid = valid_reg;

endmodule

// File: rtl/demux64_dist.sv
// Registered 1-to-N_OUT distributor: direct lane select or frame-fill pointer walk.
module demux64_dist
   import demux64_pkg::*;
#(
   parameter int N_OUT  = N_OUT_DEFAULT,
   parameter int SEL_W  = SEL_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_W-1:0]       din,
   input  logic                    din_valid,
   output logic                    din_ready,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    mode,
   input  logic                    start,
   output logic                    busy,
   output logic                    frame_done,
   output logic [SEL_W-1:0]        ptr,
   output logic [N_OUT*DATA_W-1:0] lane_data,
   output logic [N_OUT-1:0]        lane_valid,
   input  logic [N_OUT-1:0]        lane_ack
);

   state_t           state_reg;
   logic [SEL_W-1:0] ptr_reg;
   logic             busy_reg;
   logic             done_reg;

   logic [SEL_W-1:0] tgt;
   logic             mode_ok;
   logic             slot_free;
   logic             xfer;

   assign tgt       = mode ? ptr_reg : sel;
   assign mode_ok   = (state_reg != DONE) && (!mode || (state_reg == FILL));
   // An ack on the target lane frees it in time for this cycle's write.
   assign slot_free = !lane_valid[tgt] || lane_ack[tgt];
   assign din_ready = rst_n && mode_ok && slot_free;
   assign xfer      = din_valid && din_ready;

   generate
      for (genvar gi = 0; gi < N_OUT; gi++) begin : g_lane
         logic wr;
         assign wr = xfer && (tgt == SEL_W'(gi));

         demux_lane #(
            .DATA_W (DATA_W)
         ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .wr    (wr),
            .wdata (din),
            .ack   (lane_ack[gi]),
            .data  (lane_data[lane_lsb(gi, DATA_W) +: DATA_W]),
            .valid (lane_valid[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start && mode) begin
                  state_reg <= FILL;
                  ptr_reg   <= '0;
                  busy_reg  <= 1'b1;
               end
            end
            FILL: begin
               if (xfer) begin
                  if (ptr_reg == SEL_W'(N_OUT - 1)) begin
                     ptr_reg   <= '0;
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                  end else begin
                     ptr_reg <= ptr_reg + 1'b1;
                  end
               end
            end
            DONE: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = busy_reg;
   assign frame_done = done_reg;
   assign ptr        = ptr_reg;

endmodule

// File: doc/demux64_dist.md
Name: demux64_dist

Overview:
- Registered 1-to-64 distributor. It is the inverse of the 64:1 select tree: one input stream is steered to one of 64 output lanes.
- Each lane holds one datum until its consumer acknowledges it.
- Two addressing modes:
  - direct: the lane comes from `sel`.
  - frame-fill: an internal pointer walks lanes 0..63 and signals frame completion.
- It sits on the write side of the mux64 datapath and repopulates the 64-entry source bank that the mux tree reads.

Parameters:
- N_OUT, 64, number of output lanes (power of two, >=2)
- SEL_W, 6, log2(N_OUT)
- DATA_W, 1, datum width per lane

Ports:
- clk  in  1  single clock; all state is updated on its rising edge
- rst_n  in  1  asynchronous, active-low reset; release is synchronous to clk
- din  in  DATA_W  input datum
- din_valid  in  1  datum offered
- din_ready  out  1  block accepts the datum this cycle
- sel  in  SEL_W  target lane in direct mode
- mode  in  1  0 = direct, 1 = frame-fill
- start  in  1  one-cycle pulse that begins a frame-fill pass
- busy  out  1  a frame-fill pass is in progress
- frame_done  out  1  one-cycle pulse after lane N_OUT-1 is written in frame-fill
- ptr  out  SEL_W  current frame-fill pointer
- lane_data  out  N_OUT*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W]
- lane_valid  out  N_OUT  lane k holds an unconsumed datum
- lane_ack  in  N_OUT  consumer of lane k takes its datum

Behaviour:
- Reset (async assert):
  - lane_data = 0, lane_valid = 0, ptr = 0.
  - busy = 0, frame_done = 0, FSM = IDLE.
  - din_ready = 0 while rst_n is low.
- Target lane:
  - T = sel when mode = 0.
  - T = ptr when mode = 1.
  - mode and sel are sampled every cycle. Changing mode while busy is illegal; assertion in the bench.
- din_ready (combinational):
  - Requires FSM != DONE and (mode = 0 or FSM = FILL).
  - Requires (!lane_valid[T] or lane_ack[T]).
- Transfer: din_valid and din_ready at a rising edge. Then lane_data[T] <= din and lane_valid[T] <= 1.
- Latency: a datum is visible on lane_data/lane_valid 1 cycle after acceptance.
- Per lane k, when both ack and write happen:
  - If lane_ack[k] is set and lane k is not written that cycle, lane_valid[k] <= 0.
  - Ack and write to the same lane in the same cycle give lane_valid stays 1 with the new data (pass-through refill, full throughput).
  - lane_ack[k] while lane_valid[k] = 0 is ignored.
- lane_data is not cleared on ack; it holds its last value.
- FSM states:
  - IDLE:
    - busy = 0.
    - start with mode = 1 -> FILL, ptr <= 0.
    - start in mode 0 is ignored.
  - FILL:
    - busy = 1.
    - On each transfer, ptr <= ptr + 1.
    - A transfer with ptr = N_OUT-1 sets ptr <= 0 (wrap) and moves to DONE.
  - DONE:
    - frame_done = 1 for exactly this cycle; din_ready = 0.
    - Next state is always IDLE.
- start while FILL or DONE is ignored; a pass is never restarted mid-frame.
- Back-pressure: a stalled lane (valid, not acked) blocks the frame. ptr does not advance and no later lane is written out of order.
- Reset mid-frame: all state returns to reset values immediately, and a partial frame is discarded.

Decomposition:
- Shared package demux64_pkg holds:
  - N_OUT, SEL_W, DATA_W defaults.
  - FSM state typedef: IDLE=2'd0, FILL=2'd1, DONE=2'd2.
  - Lane-slice index helper.
- One natural sub-module, demux_lane: a one-entry holding register with write, data and ack inputs and data/valid outputs.
- The top generates N_OUT instances plus the decoder, pointer and FSM.

Test Plan:
- Reset: assert rst_n = 0 mid-transfer.
  -> All lane_valid = 0, ptr = 0, busy = 0, din_ready = 0 within the same cycle, before any clock edge.
- Direct writes: mode = 0.
  - Send sel = 5, din = 1, then sel = 63, din = 1.
  - -> lane_valid = bit5|bit63, and lane_data[5] = lane_data[63] = 1, one cycle after each transfer.
- Back-pressure: mode = 0, lane 5 valid with no ack, offer sel = 5.
  - -> din_ready = 0.
  - Then pulse lane_ack[5] together with the write -> lane_valid[5] stays 1 with the new data.
- Frame-fill: mode = 1, start, then 64 back-to-back transfers of alternating data 1/0.
  - -> ptr runs 0..63.
  - -> frame_done pulses exactly once, on the cycle after transfer 64.
  - -> lane_data pattern = 0x5555…5 (even lanes = 1); busy drops on the cycle after frame_done.
- Stall in frame: hold lane 10 valid without ack while ptr = 10.
  - -> ptr stays 10 and din_ready = 0.
  - -> Release the ack and filling resumes at lane 10.
- Start during FILL, and reset mid-frame after lane 20.
  - -> Start is ignored.
  - -> After reset, ptr = 0 and a new start refills from lane 0.
